// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the float32 multiplier arbiter.
package fp_arb_pkg;

    localparam int unsigned C_FP_DWIDTH = 32;
    localparam int unsigned C_MAX_REQ   = 8;
    localparam int unsigned C_PICK_W    = 3;

    typedef logic [C_FP_DWIDTH-1:0] float_t;

    // Result of a round-robin search: whether anyone won, and who.
    typedef struct packed {
        logic                found;
        logic [C_PICK_W-1:0] id;
    } rr_pick_t;

    // Width of a requester id; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First eligible requester at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(input logic [C_MAX_REQ-1:0] elig,
                                         input logic [C_PICK_W-1:0]  ptr,
                                         input int unsigned          n);
        rr_pick_t    r;
        int unsigned idx;
        r = '0;
        for (int unsigned k = 0; k < C_MAX_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !r.found && elig[idx[C_PICK_W-1:0]]) begin
                r.found = 1'b1;
                r.id    = C_PICK_W'(idx);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// Per-requester result FIFO: registered write, first-word-fallthrough read.
module fp_result_fifo
    import fp_arb_pkg::*;
#(
    parameter int unsigned G_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  float_t                   wr_data_i,
    input  logic                     rd_en_i,
    output float_t                   rd_data_o,
    output logic [$clog2(G_DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(G_DEPTH);
    localparam int unsigned CW = AW + 1;

    float_t          mem_q [G_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_wr_c, do_rd_c;

    // Accept/advance decisions; a write into a full FIFO is only taken alongside a pop.
    always_comb begin
        do_rd_c  = rd_en_i & (count_q != '0);
        do_wr_c  = wr_en_i & ((count_q != CW'(G_DEPTH)) | do_rd_c);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr_c, do_rd_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until counted.
    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin, credit-gated sharing of one fixed-latency float32 multiplier.
module fp_mult_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned G_NUM_REQ      = 4,
    parameter int unsigned G_MULT_LATENCY = 6,
    parameter int unsigned G_FIFO_DEPTH   = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [G_NUM_REQ*C_FP_DWIDTH-1:0] req_din1,
    input  logic [G_NUM_REQ*C_FP_DWIDTH-1:0] req_din2,
    input  logic [G_NUM_REQ-1:0]             req_valid,
    output logic [G_NUM_REQ-1:0]             req_ready,
    output logic [G_NUM_REQ*C_FP_DWIDTH-1:0] rsp_dout,
    output logic [G_NUM_REQ-1:0]             rsp_valid,
    input  logic [G_NUM_REQ-1:0]             rsp_ready,
    output float_t                           mult_din1,
    output float_t                           mult_din2,
    output logic                             mult_din_valid,
    input  float_t                           mult_dout,
    input  logic                             mult_dout_valid,
    output logic                             tag_err
);

    localparam int unsigned ID_W  = id_width(G_NUM_REQ);
    localparam int unsigned CNT_W = $clog2(G_FIFO_DEPTH) + 1;
    localparam int unsigned SUP_W = $clog2(G_MULT_LATENCY + 1);

    typedef logic [ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    logic                 clear_c, active_c;
    logic [G_NUM_REQ-1:0] elig_c, grant_c, pop_c, wr_sel_c;
    rr_pick_t             pick_c;
    req_id_t              grant_id_c;
    req_id_t              rr_q, rr_d;
    float_t               din1_q, din1_d, din2_q, din2_d;
    tag_t                 tag_pipe_q [G_MULT_LATENCY+1];
    tag_t                 tag_pipe_d [G_MULT_LATENCY+1];
    tag_t                 tag_out_c;
    logic [CNT_W-1:0]     credit_q [G_NUM_REQ];
    logic [CNT_W-1:0]     credit_d [G_NUM_REQ];
    logic [CNT_W-1:0]     fifo_count [G_NUM_REQ];
    logic [SUP_W-1:0]     sup_q, sup_d;
    logic                 tag_err_q, tag_err_d;
    logic                 wr_en_c, mismatch_c;

    // Eligibility and round-robin grant; at most one requester wins per cycle.
    always_comb begin
        clear_c  = reset | ~enable;
        active_c = ~clear_c;
        for (int i = 0; i < G_NUM_REQ; i++) begin
            elig_c[i] = active_c & req_valid[i] & (credit_q[i] != '0);
        end
        pick_c     = rr_pick(C_MAX_REQ'(elig_c), C_PICK_W'(rr_q), G_NUM_REQ);
        grant_id_c = ID_W'(pick_c.id);
        for (int i = 0; i < G_NUM_REQ; i++) begin
            grant_c[i] = pick_c.found & (pick_c.id == C_PICK_W'(i));
        end
    end

    assign req_ready = grant_c;

    // Issue stage and tag shift register; stage 0 travels with mult_din_valid.
    always_comb begin
        din1_d = din1_q;
        din2_d = din2_q;
        rr_d   = rr_q;
        tag_pipe_d[0]       = tag_pipe_q[0];
        tag_pipe_d[0].valid = 1'b0;
        for (int k = 1; k <= G_MULT_LATENCY; k++) begin
            tag_pipe_d[k] = tag_pipe_q[k-1];
        end
        if (pick_c.found) begin
            din1_d              = req_din1[grant_id_c*C_FP_DWIDTH +: C_FP_DWIDTH];
            din2_d              = req_din2[grant_id_c*C_FP_DWIDTH +: C_FP_DWIDTH];
            tag_pipe_d[0].valid = 1'b1;
            tag_pipe_d[0].id    = grant_id_c;
            rr_d = (grant_id_c == ID_W'(G_NUM_REQ - 1)) ? '0 : ID_W'(grant_id_c + ID_W'(1));
        end
    end

    // Writeback routing and tag/result consistency check, masked right after a clear.
    always_comb begin
        tag_out_c  = tag_pipe_q[G_MULT_LATENCY];
        wr_en_c    = active_c & mult_dout_valid & tag_out_c.valid;
        mismatch_c = active_c & (sup_q == '0) & (mult_dout_valid ^ tag_out_c.valid);
        tag_err_d  = tag_err_q | mismatch_c;
        sup_d      = (sup_q != '0) ? SUP_W'(sup_q - SUP_W'(1)) : '0;
        for (int i = 0; i < G_NUM_REQ; i++) begin
            wr_sel_c[i] = wr_en_c & (tag_out_c.id == ID_W'(i));
        end
    end

    // Result visibility, pops and credit bookkeeping.
    always_comb begin
        for (int i = 0; i < G_NUM_REQ; i++) begin
            rsp_valid[i] = active_c & (fifo_count[i] != '0);
            pop_c[i]     = rsp_valid[i] & rsp_ready[i];
            case ({grant_c[i], pop_c[i]})
                2'b10:   credit_d[i] = credit_q[i] - CNT_W'(1);
                2'b01:   credit_d[i] = credit_q[i] + CNT_W'(1);
                default: credit_d[i] = credit_q[i];
            endcase
        end
    end

    // Arbiter state registers; reset and enable=0 clear identically.
    always_ff @(posedge clk) begin
        if (clear_c) begin
            rr_q      <= '0;
            din1_q    <= '0;
            din2_q    <= '0;
            sup_q     <= SUP_W'(G_MULT_LATENCY);
            tag_err_q <= 1'b0;
            for (int k = 0; k <= G_MULT_LATENCY; k++) begin
                tag_pipe_q[k] <= '0;
            end
            for (int i = 0; i < G_NUM_REQ; i++) begin
                credit_q[i] <= CNT_W'(G_FIFO_DEPTH);
            end
        end else begin
            rr_q      <= rr_d;
            din1_q    <= din1_d;
            din2_q    <= din2_d;
            sup_q     <= sup_d;
            tag_err_q <= tag_err_d;
            for (int k = 0; k <= G_MULT_LATENCY; k++) begin
                tag_pipe_q[k] <= tag_pipe_d[k];
            end
            for (int i = 0; i < G_NUM_REQ; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    // One result FIFO per requester.
    for (genvar i = 0; i < G_NUM_REQ; i++) begin : g_fifo
        fp_result_fifo #(
            .G_DEPTH (G_FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .clear_i   (clear_c),
            .wr_en_i   (wr_sel_c[i]),
            .wr_data_i (mult_dout),
            .rd_en_i   (pop_c[i]),
            .rd_data_o (rsp_dout[i*C_FP_DWIDTH +: C_FP_DWIDTH]),
            .count_o   (fifo_count[i])
        );
    end

    assign mult_din1      = din1_q;
    assign mult_din2      = din2_q;
    assign mult_din_valid = tag_pipe_q[0].valid;
    assign tag_err        = tag_err_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Randomised and directed bench for fp_mult_arbiter against a transaction-level model.
module tb_fp_mult_arbiter;
    import fp_arb_pkg::*;

    localparam int N = 4;
    localparam int L = 6;
    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Applied inputs (changed only just after a falling edge).
    logic         rst_drv = 1'b1, en_drv = 1'b1, inj_drv = 1'b0;
    logic [N-1:0] v_drv = '0, rr_drv = '0;
    float_t       op_a [N];
    float_t       op_b [N];
    // Requested inputs for the next step.
    logic   p_rst = 1'b0, p_en = 1'b1, p_inj = 1'b0;
    int     fix_req = -1;
    float_t fix_a = '0, fix_b = '0;

    logic [N*32-1:0] din1_w, din2_w, rsp_dout_w;
    logic [N-1:0]    req_ready_w, rsp_valid_w;
    float_t          mult_din1_w, mult_din2_w, mult_dout_w;
    logic            mult_din_valid_w, mult_dout_valid_w, tag_err_w;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            din1_w[i*32 +: 32] = op_a[i];
            din2_w[i*32 +: 32] = op_b[i];
        end
    end

    fp_mult_arbiter #(.G_NUM_REQ(N), .G_MULT_LATENCY(L), .G_FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(rst_drv), .enable(en_drv),
        .req_din1(din1_w), .req_din2(din2_w), .req_valid(v_drv), .req_ready(req_ready_w),
        .rsp_dout(rsp_dout_w), .rsp_valid(rsp_valid_w), .rsp_ready(rr_drv),
        .mult_din1(mult_din1_w), .mult_din2(mult_din2_w), .mult_din_valid(mult_din_valid_w),
        .mult_dout(mult_dout_w), .mult_dout_valid(mult_dout_valid_w), .tag_err(tag_err_w)
    );

    // Float32 product for normal operands whose mantissa product is exact.
    function automatic float_t fp_mul(input float_t a, input float_t b);
        logic [47:0] p;
        logic [9:0]  e;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) begin
            e = e + 10'd1;
            return {a[31] ^ b[31], e[7:0], p[46:24]};
        end
        return {a[31] ^ b[31], e[7:0], p[45:23]};
    endfunction

    function automatic float_t rand_fp();
        return {1'($urandom), 8'(100 + $urandom_range(50)), 8'($urandom), 15'd0};
    endfunction

    // Behavioural multiplier: latency L, not affected by the arbiter's reset.
    logic   mrst = 1'b1;
    logic   mv [L];
    float_t md [L];
    always @(posedge clk) begin
        if (mrst) begin
            for (int k = 0; k < L; k++) begin
                mv[k] <= 1'b0;
                md[k] <= '0;
            end
        end else begin
            mv[0] <= mult_din_valid_w;
            md[0] <= fp_mul(mult_din1_w, mult_din2_w);
            for (int k = 1; k < L; k++) begin
                mv[k] <= mv[k-1];
                md[k] <= md[k-1];
            end
        end
    end
    assign mult_dout_valid_w = mv[L-1] | inj_drv;
    assign mult_dout_w       = md[L-1];

    // Reference model: outstanding results as (requester, visible-from cycle, value).
    typedef struct {
        int     id;
        int     rdy;
        float_t val;
    } res_t;
    res_t   mq [$];
    int     out_cnt [N];
    int     ptr = 0;
    logic   m_dv = 1'b0, m_err = 1'b0;
    float_t m_d1 = '0, m_d2 = '0;
    int     cyc = 0;
    int     n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare every output with the model, advance the model.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] r);
        logic         clr, due, found;
        int           g, idx;
        int           hidx [N];
        logic [N-1:0] e_rdy, e_rv;
        @(negedge clk);
        rst_drv = p_rst; en_drv = p_en; inj_drv = p_inj;
        v_drv = v; rr_drv = r;
        for (int i = 0; i < N; i++) begin
            op_a[i] = rand_fp();
            op_b[i] = rand_fp();
        end
        if (fix_req >= 0) begin
            op_a[fix_req] = fix_a;
            op_b[fix_req] = fix_b;
        end
        #1;
        clr = rst_drv || !en_drv;
        g = -1;
        if (!clr) begin
            for (int k = 0; k < N; k++) begin
                idx = (ptr + k) % N;
                if (g < 0 && v[idx] && out_cnt[idx] < D) g = idx;
            end
        end
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready_w), 32'(e_rdy));
        for (int i = 0; i < N; i++) hidx[i] = -1;
        foreach (mq[j]) if (hidx[mq[j].id] < 0) hidx[mq[j].id] = j;
        for (int i = 0; i < N; i++) begin
            e_rv[i] = !clr && hidx[i] >= 0 && mq[hidx[i]].rdy <= cyc;
        end
        chk("rsp_valid", 32'(rsp_valid_w), 32'(e_rv));
        for (int i = 0; i < N; i++) begin
            if (e_rv[i]) chk("rsp_dout", rsp_dout_w[i*32 +: 32], mq[hidx[i]].val);
        end
        chk("mult_din_valid", 32'(mult_din_valid_w), 32'(m_dv));
        chk("mult_din1", mult_din1_w, m_d1);
        chk("mult_din2", mult_din2_w, m_d2);
        chk("tag_err", 32'(tag_err_w), 32'(m_err));
        due = 1'b0;
        foreach (mq[j]) if (mq[j].rdy == cyc + 1) due = 1'b1;
        if (clr) begin
            mq.delete();
            for (int i = 0; i < N; i++) out_cnt[i] = 0;
            ptr = 0; m_dv = 1'b0; m_d1 = '0; m_d2 = '0; m_err = 1'b0;
        end else begin
            if (inj_drv && !due) m_err = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (e_rv[i] && r[i]) begin
                    found = 1'b0; idx = 0;
                    foreach (mq[j]) if (!found && mq[j].id == i) begin found = 1'b1; idx = j; end
                    mq.delete(idx);
                    out_cnt[i]--;
                end
            end
            if (g >= 0) begin
                mq.push_back('{g, cyc + 2 + L, fp_mul(op_a[g], op_b[g])});
                out_cnt[g]++;
                ptr  = (g + 1) % N;
                m_dv = 1'b1; m_d1 = op_a[g]; m_d2 = op_b[g];
            end else begin
                m_dv = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        p_rst = 1'b1;
        step('0, '0);
        p_rst = 1'b0;
    endtask

    int cnt, cnt3;

    initial begin
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0; op_b[i] = '0; out_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        mrst = 1'b0;
        do_reset();

        // Single request: 2.0 x 3.0 visible exactly 8 cycles after the handshake.
        fix_req = 0; fix_a = 32'h40000000; fix_b = 32'h40400000;
        step(4'b0001, 4'b1111);
        chk("t1_grant", 32'(req_ready_w), 32'h1);
        fix_req = -1;
        repeat (7) step('0, 4'b1111);
        chk("t1_early", 32'(rsp_valid_w), 32'h0);
        step('0, 4'b1111);
        chk("t1_valid", 32'(rsp_valid_w), 32'h1);
        chk("t1_dout", rsp_dout_w[31:0], 32'h40C00000);

        // All requesters continuously valid: strict rotation, requester 2 squares 1.5.
        do_reset();
        fix_req = 2; fix_a = 32'h3FC00000; fix_b = 32'h3FC00000;
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step(4'b1111, 4'b1111);
            chk("t2_rotation", 32'(req_ready_w), 32'(1 << (k % 4)));
            if (k > 0) chk("t2_din_valid", 32'(mult_din_valid_w), 32'h1);
            if (rsp_valid_w[2]) begin
                chk("t2_req2_dout", rsp_dout_w[95:64], 32'h40100000);
                cnt++;
            end
        end
        chk("t2_req2_seen", 32'(cnt > 3), 32'h1);
        fix_req = -1;

        // Requester 1 never drained: exactly D grants, requester 3 keeps going.
        do_reset();
        cnt = 0; cnt3 = 0;
        for (int k = 0; k < 30; k++) begin
            step(4'b1010, 4'b1000);
            if (req_ready_w[1]) cnt++;
            if (k >= 20 && req_ready_w[3]) cnt3++;
        end
        chk("t3_req1_grants", 32'(cnt), 32'(D));
        chk("t3_req3_alive", 32'(cnt3 >= 5), 32'h1);
        cnt = 0;
        step(4'b1010, 4'b1010);
        if (req_ready_w[1]) cnt++;
        repeat (10) begin
            step(4'b1010, 4'b1000);
            if (req_ready_w[1]) cnt++;
        end
        chk("t3_one_more", 32'(cnt), 32'h1);

        // Credit boundary: grant and pop together at credit 1.
        do_reset();
        repeat (7) step(4'b0001, 4'b0000);
        repeat (10) step('0, 4'b0000);
        step(4'b0001, 4'b0001);
        chk("t4_grant_pop", 32'({req_ready_w[0], rsp_valid_w[0]}), 32'h3);
        step(4'b0001, 4'b0000);
        chk("t4_last_credit", 32'(req_ready_w), 32'h1);
        step(4'b0001, 4'b0000);
        chk("t4_no_credit", 32'(req_ready_w), 32'h0);
        repeat (20) step('0, 4'b1111);
        chk("t4_drained", 32'(rsp_valid_w), 32'h0);

        // Reset, then enable=0, each with three operations in flight.
        for (int pass = 0; pass < 2; pass++) begin
            repeat (3) step(4'b1111, 4'b1111);
            if (pass == 0) p_rst = 1'b1; else p_en = 1'b0;
            step('0, 4'b1111);
            p_rst = 1'b0; p_en = 1'b1;
            step('0, 4'b1111);
            chk("t5_din_valid", 32'(mult_din_valid_w), 32'h0);
            chk("t5_din1", mult_din1_w, 32'h0);
            chk("t5_tag_err", 32'(tag_err_w), 32'h0);
            repeat (10) step('0, 4'b1111);
            chk("t5_no_stale", 32'({tag_err_w, rsp_valid_w}), 32'h0);
            cnt = 0;
            repeat (12) begin
                step(4'b0001, 4'b0000);
                if (req_ready_w[0]) cnt++;
            end
            chk("t5_credits", 32'(cnt), 32'(D));
            repeat (20) step('0, 4'b1111);
        end

        // Random traffic with occasional enable drops.
        repeat (1500) begin
            p_en = ($urandom_range(299) != 0);
            step(4'($urandom), 4'($urandom) | 4'($urandom));
        end
        p_en = 1'b1;
        repeat (20) step('0, 4'b1111);

        // Spurious multiplier output: sticky error, nothing written.
        p_inj = 1'b1;
        step('0, 4'b1111);
        p_inj = 1'b0;
        step('0, 4'b1111);
        chk("t6_tag_err", 32'(tag_err_w), 32'h1);
        repeat (5) step('0, 4'b1111);
        chk("t6_sticky", 32'({tag_err_w, rsp_valid_w}), 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one fixed-latency, valid-only float32 multiplier (no backpressure) between G_NUM_REQ requesters, e.g. polynomial-estimator stages or parallel estimators.
- Round-robin arbitration, one issue per cycle. Each issue is tagged with its requester ID, and the result is routed back into a per-requester result FIFO.
- Issue is credit-gated, so a result FIFO can never overflow even though the multiplier cannot stall.

Parameters:
- G_NUM_REQ, 4: number of requesters (2..8).
- G_MULT_LATENCY, 6: cycles from mult_din_valid to mult_dout_valid. Must match the attached multiplier.
- G_FIFO_DEPTH, 8: result FIFO depth per requester, power of two, >= 2.
- C_FP_DWIDTH (localparam), 32: IEEE-754 single-precision width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  0 = synchronous clear, identical to reset.
- req_din1  in  G_NUM_REQ*32  operand A, requester i at bits [32i+31:32i].
- req_din2  in  G_NUM_REQ*32  operand B, same packing.
- req_valid  in  G_NUM_REQ  request valid per requester.
- req_ready  out  G_NUM_REQ  grant/accept per requester.
- rsp_dout  out  G_NUM_REQ*32  product per requester, same packing.
- rsp_valid  out  G_NUM_REQ  result available.
- rsp_ready  in  G_NUM_REQ  result consumed.
- mult_din1  out  32  to multiplier.
- mult_din2  out  32  to multiplier.
- mult_din_valid  out  1  to multiplier.
- mult_dout  in  32  from multiplier.
- mult_dout_valid  in  1  from multiplier.
- tag_err  out  1  sticky: result/tag pipeline mismatch.

Behaviour:
- Reset or enable=0:
  - mult_din1/2=0, mult_din_valid=0, tag pipeline cleared, FIFOs emptied.
  - credit[i]=G_FIFO_DEPTH, rr pointer=0, tag_err=0.
  - req_ready=0 and rsp_valid=0 while reset or !enable.
- Eligibility: requester i is eligible when req_valid[i]=1 and credit[i]>0.
- Grant:
  - Combinational round-robin over eligible requesters, starting at rr pointer; at most one req_ready bit high.
  - req_ready[i] may depend on req_valid; requesters must not depend on req_ready to assert valid.
- Issue, on handshake of requester g in cycle T:
  - Register req_din1/2[g] to mult_din1/2; mult_din_valid=1 in cycle T+1. With no handshake, mult_din_valid=0 and data holds.
  - rr pointer <= (g+1) mod G_NUM_REQ. No handshake leaves the pointer unchanged.
  - credit[g] decrements.
- Tag pipeline:
  - G_MULT_LATENCY-deep shift register of {valid, id}, loaded in step with mult_din_valid.
  - Its output is aligned with mult_dout_valid.
- Writeback: when mult_dout_valid=1, write mult_dout into FIFO[tag id].
- Latency: result visible at rsp_valid/rsp_dout in cycle T+2+G_MULT_LATENCY (FIFO registered write, first-word-fallthrough read). Full throughput: 1 issue/cycle aggregate.
- Result FIFO:
  - rsp_valid[i] = (count[i]>0); rsp_dout[i] = head.
  - Pop on rsp_valid[i] & rsp_ready[i].
  - Write and pop in the same cycle are both honoured; count unchanged.
- Credits: credit[i] counts FIFO slots not occupied and not reserved by in-flight ops.
  - -1 on grant, +1 on pop, unchanged when both occur in the same cycle.
  - Range 0..G_FIFO_DEPTH. With credit=0 the requester is skipped, not stalled for others.
- Ordering: results per requester are returned in issue order. There is no ordering between requesters.
- tag_err is set (sticky until reset) in either case below. In both cases the result is dropped:
  - mult_dout_valid=1 while the tag output is invalid.
  - The tag output is valid while mult_dout_valid=0.
- Reset mid-operation: in-flight products arriving after reset are ignored, because the tag pipeline is cleared. They do not set tag_err, which is suppressed for G_MULT_LATENCY cycles after reset/enable deassert.

Decomposition:
- Package fp_arb_pkg: float_t (logic [31:0]), C_FP_DWIDTH, req_id_t (logic [$clog2(G_NUM_REQ)-1:0]) width function, and a round-robin pick function.
- One sub-module: fp_result_fifo (sync FIFO, first-word-fallthrough, count output), instantiated G_NUM_REQ times.
- The multiplier stays outside; the bench uses a latency-L behavioural model.

Test Plan:
1. Single request: req 0 issues 0x40000000 × 0x40400000 at cycle T -> rsp_valid[0] at T+8 (L=6), rsp_dout[0]=0x40C00000; other rsp_valid stay 0.
2. All four valid continuously, rsp_ready=1111 -> grants strictly 0,1,2,3,0,… one per cycle. Requester 2 (1.5×1.5) gets 0x40100000 in order; mult_din_valid held at 1.
3. Requester 1 valid, rsp_ready[1]=0 -> exactly 8 handshakes, then req_ready[1]=0. Requester 3 is still granted. Raising rsp_ready[1] one cycle restores one grant.
4. Credit boundary: credit[0]=1, and grant and pop occur in the same cycle -> credit stays 1, with no FIFO overflow or underflow.
5. Reset asserted with 3 ops in flight -> all outputs at reset values next cycle. Stale mult_dout_valid pulses are ignored, tag_err=0, credits=8.
6. Model injects a spurious mult_dout_valid pulse -> tag_err=1 and stays 1. No FIFO write occurs.
